two24_sat_buf: RTL and testbench

Downstream consumer for the TWO24 SIMD DSP48E2 add/subtract stage. It tracks which DSP outputs are valid with a LATENCY-deep valid delay line and clamps each 24-bit lane on carry according to SAT_MODE. It counts saturation events per lane and buffers results in a credit-managed FWFT FIFO, so a free-running DSP (no CE gating) can feed a valid/ready consumer without data loss.

---
 rtl/two24_sat_buf.sv | 154 +++++++++++++++
 tb/tb_two24_sat_buf.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/two24_sat_buf.sv
// two24_sat_buf: consumer for a free-running TWO24 SIMD add/sub DSP stage.
// Samples are tracked through the DSP with a valid delay line, clamped per
// 24-bit lane on carry, counted, and stored in a credit-managed FWFT FIFO.
// Credits guarantee that every sample in the DSP pipeline has a FIFO slot
// when it emerges, because the DSP cannot be stalled.

// Per-lane saturation logic and sticky event counter.
module two24_sat_lane #(
    parameter int SAT_MODE = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             arrive,
    input  logic             clr,
    input  logic [23:0]      p,
    input  logic             carry,
    output logic [23:0]      lane,
    output logic             ev,
    output logic [CNT_W-1:0] cnt
);

    // Event detect and clamp; subtract saturates on borrow (carry low).
    always_comb begin
        ev   = (SAT_MODE == 2) ? ~carry : carry;
        lane = p;
        if (SAT_MODE == 1 && ev)
            lane = 24'hFFFFFF;
        else if (SAT_MODE == 2 && ev)
            lane = 24'h000000;
    end

    // Sticky counter; a clear still records an event landing in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt <= '0;
        else if (clr)
            cnt <= CNT_W'(arrive & ev);
        else if (arrive && ev && cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

module two24_sat_buf #(
    parameter int LATENCY  = 2,
    parameter int SAT_MODE = 1,
    parameter int FIFO_AW  = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [47:0]      P_i,
    input  logic [1:0]       CARRY_i,
    output logic [47:0]      out_data_o,
    output logic [1:0]       out_ovf_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] sat_cnt0_o,
    output logic [CNT_W-1:0] sat_cnt1_o
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int AW_S  = (FIFO_AW > 0) ? FIFO_AW : 1;

    logic                    accept, arrive, pop;
    logic [LATENCY:1]        vld_pipe;
    logic [CW-1:0]           inflight, fifo_count;
    logic [CW:0]             credit_sum;
    logic [1:0][23:0]        lane_data;
    logic [1:0]              ev;
    logic [1:0][CNT_W-1:0]   sat_cnt;
    logic [DEPTH-1:0][49:0]  mem;
    logic [AW_S-1:0]         wr_ptr, rd_ptr;
    logic [49:0]             head;

    // Credits: every accepted sample owns a slot from accept until pop.
    assign credit_sum  = {1'b0, fifo_count} + {1'b0, inflight};
    assign in_ready_o  = rst_n_i & (credit_sum < (CW+1)'(DEPTH));
    assign accept      = in_valid_i & in_ready_o;
    assign arrive      = vld_pipe[LATENCY];
    assign out_valid_o = (fifo_count != '0);
    assign pop         = out_valid_o & out_ready_i;

    // Valid delay line mirrors the DSP register stages; it never stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= accept;
            for (int i = 2; i <= LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // In-flight and occupancy counters, updated together each cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight   <= '0;
            fifo_count <= '0;
        end else begin
            inflight   <= inflight + CW'(accept) - CW'(arrive);
            fifo_count <= fifo_count + CW'(arrive) - CW'(pop);
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_lane
        two24_sat_lane #(.SAT_MODE(SAT_MODE), .CNT_W(CNT_W)) u_lane (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .arrive  (arrive),
            .clr     (clr_cnt_i),
            .p       (P_i[24*k +: 24]),
            .carry   (CARRY_i[k]),
            .lane    (lane_data[k]),
            .ev      (ev[k]),
            .cnt     (sat_cnt[k])
        );
    end

    assign sat_cnt0_o = sat_cnt[0];
    assign sat_cnt1_o = sat_cnt[1];

    // FIFO storage and pointers; push on arrive, pop on handshake.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (arrive) begin
                mem[wr_ptr] <= {ev, lane_data};
                wr_ptr      <= (wr_ptr == AW_S'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == AW_S'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    assign head       = mem[rd_ptr];
    assign out_data_o = head[47:0];
    assign out_ovf_o  = head[49:48];

    // The credit rule makes an arrive into a full FIFO impossible.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && arrive)
            assert (fifo_count < CW'(DEPTH));
    end

endmodule

// File: tb/tb_two24_sat_buf.sv
// Directed bench for two24_sat_buf: one add-mode and one subtract-mode
// instance share the same stimulus; a small DSP pipeline model feeds P/CARRY.
module tb_two24_sat_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
    logic [47:0] P = '0, ab_in = '0, ab_r = '0;
    logic [1:0]  C = '0, c_in = '0, c_r = '0;

    logic        a_ready, a_valid, b_ready, b_valid;
    logic [47:0] a_data, b_data;
    logic [1:0]  a_ovf, b_ovf;
    logic [3:0]  a_cnt0, a_cnt1, b_cnt0, b_cnt1;

    int tests = 0, fails = 0, acc_cnt = 0;
    logic [49:0] sb[$];

    always #5 clk = ~clk;

    two24_sat_buf #(.LATENCY(2), .SAT_MODE(1), .FIFO_AW(2), .CNT_W(4)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(a_ready),
        .P_i(P), .CARRY_i(C), .out_data_o(a_data), .out_ovf_o(a_ovf),
        .out_valid_o(a_valid), .out_ready_i(out_ready), .clr_cnt_i(clr),
        .sat_cnt0_o(a_cnt0), .sat_cnt1_o(a_cnt1));

    two24_sat_buf #(.LATENCY(2), .SAT_MODE(2), .FIFO_AW(2), .CNT_W(4)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(b_ready),
        .P_i(P), .CARRY_i(C), .out_data_o(b_data), .out_ovf_o(b_ovf),
        .out_valid_o(b_valid), .out_ready_i(out_ready), .clr_cnt_i(clr),
        .sat_cnt0_o(b_cnt0), .sat_cnt1_o(b_cnt1));

    // Add-mode reference: carry forces the lane to all ones.
    function automatic logic [49:0] exp_add(input logic [47:0] p, input logic [1:0] c);
        logic [23:0] l0, l1;
        l0 = c[0] ? 24'hFFFFFF : p[23:0];
        l1 = c[1] ? 24'hFFFFFF : p[47:24];
        return {c, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: score the handshakes seen this cycle, then advance the DSP model.
    task automatic cyc();
        if (a_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
            else chk("pop_data", 64'({a_ovf, a_data}), 64'(sb.pop_front()));
        end
        if (in_valid && a_ready) begin
            sb.push_back(exp_add(ab_in, c_in));
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        P = ab_r; C = c_r; ab_r = ab_in; c_r = c_in;
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) cyc();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(a_valid), 64'd0);
    endtask

    initial begin
        int a0, gaps;
        #1 rst_n = 1'b0;
        @(negedge clk);
        repeat (5) cyc();
        chk("rst_ready", 64'(a_ready), 64'd0);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_data", 64'(a_data), 64'd0);
        chk("rst_ovf", 64'(a_ovf), 64'd0);
        chk("rst_cnt", 64'({a_cnt1, a_cnt0}), 64'd0);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 64'(a_ready), 64'd1);

        // First-sample latency: accept at t, visible at t+3.
        in_valid = 1'b1; ab_in = 48'h000020_000010; c_in = 2'b00;
        cyc();
        in_valid = 1'b0;
        chk("lat_t1", 64'(a_valid), 64'd0);
        cyc();
        chk("lat_t2", 64'(a_valid), 64'd0);
        cyc();
        chk("lat_t3_valid", 64'(a_valid), 64'd1);
        chk("lat_t3_data", 64'(a_data), 64'h000020_000010);
        out_ready = 1'b1;
        cyc();

        // 64 back-to-back samples at full rate.
        a0 = acc_cnt; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ab_in = {24'(32'h20 + i), 24'(32'h10 + i)};
            cyc();
        end
        chk("stream_accepts", 64'(acc_cnt - a0), 64'd64);
        drain();

        // Saturation in both modes with CARRY=10.
        clr = 1'b1; cyc(); clr = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        ab_in = 48'h654321_123456; c_in = 2'b10;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        chk("sat_add_data", 64'(a_data), 64'hFFFFFF_123456);
        chk("sat_add_ovf", 64'(a_ovf), 64'd2);
        chk("sat_sub_data", 64'(b_data), 64'h654321_000000);
        chk("sat_sub_ovf", 64'(b_ovf), 64'd1);
        chk("sat_add_cnt", 64'({a_cnt1, a_cnt0}), 64'h10);
        chk("sat_sub_cnt", 64'({b_cnt1, b_cnt0}), 64'h01);
        c_in = 2'b00;
        drain();

        // Backpressure: four credits, then one more per pop.
        a0 = acc_cnt; out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ab_in = 48'(64'h100 + i);
            cyc();
        end
        chk("bp_accepts", 64'(acc_cnt - a0), 64'd4);
        chk("bp_ready_low", 64'(a_ready), 64'd0);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        chk("bp_ready_back", 64'(a_ready), 64'd1);
        a0 = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            ab_in = 48'(64'h200 + i);
            cyc();
        end
        chk("bp_one_more", 64'(acc_cnt - a0), 64'd1);
        drain();

        // Full FIFO then steady push/pop: output never goes idle.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin ab_in = 48'(64'h300 + i); cyc(); end
        gaps = 0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!a_valid) gaps++;
            ab_in = 48'(64'h400 + i);
            cyc();
        end
        chk("full_no_gaps", 64'(gaps), 64'd0);
        drain();

        // Random ready/valid traffic against the scoreboard.
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'($urandom()); out_ready = 1'($urandom());
            ab_in = {16'($urandom()), 32'($urandom())}; c_in = 2'($urandom());
            cyc();
        end
        drain();

        // Sticky counters with 20 lane-0 carries.
        clr = 1'b1; cyc(); clr = 1'b0;
        in_valid = 1'b1; c_in = 2'b01;
        for (int i = 0; i < 20; i++) begin ab_in = 48'(64'h500 + i); cyc(); end
        drain();
        chk("sticky_a_cnt0", 64'(a_cnt0), 64'd15);
        chk("sticky_a_cnt1", 64'(a_cnt1), 64'd0);
        chk("sticky_b_cnt1", 64'(b_cnt1), 64'd15);

        // Clear coincident with an arriving event keeps that event.
        in_valid = 1'b1; ab_in = 48'h0; c_in = 2'b01;
        cyc();
        in_valid = 1'b0;
        cyc();
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("clr_evt_a_cnt0", 64'(a_cnt0), 64'd1);
        chk("clr_evt_b_cnt1", 64'(b_cnt1), 64'd1);
        drain();

        // Reset mid-burst.
        out_ready = 1'b0; in_valid = 1'b1; c_in = 2'b00;
        for (int i = 0; i < 4; i++) begin ab_in = 48'(64'h600 + i); cyc(); end
        chk("mid_valid_pre", 64'(a_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_valid", 64'(a_valid), 64'd0);
        chk("mid_rst_ready", 64'(a_ready), 64'd0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        cyc(); cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_valid) gaps++;
            cyc();
        end
        chk("mid_no_stale", 64'(gaps), 64'd0);
        chk("mid_cnt", 64'({a_cnt1, a_cnt0}), 64'd0);
        chk("mid_ready", 64'(a_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
